// File: rtl/door_pkg.sv
// Shared types and constants for the elevator door sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package door_pkg;

  localparam int DOOR_STATE_W = 2;

  typedef enum logic [DOOR_STATE_W-1:0] {
    DOOR_CLOSED  = 2'd0,
    DOOR_OPENING = 2'd1,
    DOOR_OPEN    = 2'd2,
    DOOR_CLOSING = 2'd3
  } door_state_t;

endpackage

// File: rtl/door_tick_counter.sv
// Dwell/motion tick counter: counts door_tick pulses within one door state.
// Latency: count updates 1 clk after en; done is combinational (en & last count).
// Backpressure: none; clr and hold both force the count to zero.
// Ports:
//   clk, button_reset : clock, synchronous active-high reset
//   clr               : state change, restart count
//   en                : timebase pulse (door_tick)
//   hold              : pin count at zero (dwell restart)
//   limit             : tick count that ends the current state
//   count, done       : current count; done = en on the limit-th tick
module tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             button_reset,
  input  logic             clr,
  input  logic             en,
  input  logic             hold,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (button_reset) begin
      count <= '0;
    end else if (clr || hold) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = en & (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/door_sequencer.sv
// Elevator door controller: sequences open/dwell/close and gates car movement.
// Latency: input -> state change 1 clk; state -> motor/status outputs 0 clk.
// Backpressure: none; overload/open request hold or reverse the door, never drop.
// Ports:
//   clk, button_reset            : clock, synchronous active-high reset
//   door_tick                    : one-cycle timebase pulse
//   arrived                      : car stopped at floor (pulse)
//   open_btn, close_btn          : door requests (levels)
//   weight_limit_exceeded        : overload (level)
//   door_motor_open/close        : motor drives (OPENING / CLOSING)
//   door_is_closed, move_permit  : door status, car may move
//   door_fault, door_state       : reopen limit reached, state encoding
module door_sequencer
  import door_pkg::*;
#(
  parameter int OPEN_TICKS  = 2,
  parameter int HOLD_TICKS  = 4,
  parameter int CLOSE_TICKS = 2,
  parameter int MAX_REOPEN  = 3,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    button_reset,
  input  logic                    door_tick,
  input  logic                    arrived,
  input  logic                    open_btn,
  input  logic                    close_btn,
  input  logic                    weight_limit_exceeded,
  output logic                    door_motor_open,
  output logic                    door_motor_close,
  output logic                    door_is_closed,
  output logic                    move_permit,
  output logic                    door_fault,
  output logic [DOOR_STATE_W-1:0] door_state
);

  localparam int RC_W = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);

  door_state_t      state, state_next;
  logic [RC_W-1:0]  reopen_cnt, reopen_next;
  logic             fault_next;
  logic             reopen_evt;
  logic             enter_closed;
  logic             cnt_hold;
  logic [CNT_W-1:0] cnt_limit;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick_done;

  // Reopen requests during OPEN restart the dwell rather than ending it.
  assign cnt_hold = (state == DOOR_OPEN) & (open_btn | weight_limit_exceeded);

  always_comb begin
    cnt_limit = '0;
    case (state)
      DOOR_OPENING: cnt_limit = CNT_W'(OPEN_TICKS);
      DOOR_OPEN:    cnt_limit = CNT_W'(HOLD_TICKS);
      DOOR_CLOSING: cnt_limit = CNT_W'(CLOSE_TICKS);
      default:      cnt_limit = '0;
    endcase
  end

  tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
    .clk          (clk),
    .button_reset (button_reset),
    .clr          (state_next != state),
    .en           (door_tick),
    .hold         (cnt_hold),
    .limit        (cnt_limit),
    .count        (tick_cnt),
    .done         (tick_done)
  );

  always_ff @(posedge clk) begin
    if (button_reset) begin
      state      <= DOOR_CLOSED;
      reopen_cnt <= '0;
      door_fault <= 1'b0;
    end else begin
      state      <= state_next;
      reopen_cnt <= reopen_next;
      door_fault <= fault_next;
    end
  end

  always_comb begin
    state_next = state;
    reopen_evt = 1'b0;
    case (state)
      DOOR_CLOSED: begin
        if (arrived || open_btn) state_next = DOOR_OPENING;
      end
      DOOR_OPENING: begin
        if (tick_done) state_next = DOOR_OPEN;
      end
      DOOR_OPEN: begin
        // open request or overload wins over close request and dwell expiry
        if (open_btn || weight_limit_exceeded) state_next = DOOR_OPEN;
        else if (close_btn || tick_done)       state_next = DOOR_CLOSING;
      end
      DOOR_CLOSING: begin
        // reversal wins over completion on the same cycle
        if (open_btn || weight_limit_exceeded) begin
          state_next = DOOR_OPENING;
          reopen_evt = 1'b1;
        end else if (tick_done) begin
          state_next = DOOR_CLOSED;
        end
      end
      default: state_next = DOOR_CLOSED;
    endcase
  end

  assign enter_closed = (state_next == DOOR_CLOSED) && (state != DOOR_CLOSED);

  always_comb begin
    reopen_next = reopen_cnt;
    if (enter_closed) begin
      reopen_next = '0;
    end else if (reopen_evt && (reopen_cnt < RC_W'(MAX_REOPEN))) begin
      reopen_next = reopen_cnt + RC_W'(1);
    end
  end

  // Fault rises on the same edge the reversal count reaches the limit.
  always_comb begin
    fault_next = door_fault;
    if (enter_closed) begin
      fault_next = 1'b0;
    end else if (reopen_next == RC_W'(MAX_REOPEN)) begin
      fault_next = 1'b1;
    end
  end

  assign door_motor_open  = (state == DOOR_OPENING);
  assign door_motor_close = (state == DOOR_CLOSING);
  assign door_is_closed   = (state == DOOR_CLOSED);
  assign door_state       = state;
  assign move_permit      = door_is_closed & ~weight_limit_exceeded & ~door_fault;

endmodule

// File: tb/tb_door_sequencer.sv
// Directed bench for door_sequencer with default parameters, door_tick every 4 clks.
// Latency: n/a.
// Backpressure: n/a.
module tb_door_sequencer;

  logic       clk = 1'b0;
  logic       button_reset = 1'b0;
  logic       door_tick = 1'b0;
  logic       arrived = 1'b0;
  logic       open_btn = 1'b0;
  logic       close_btn = 1'b0;
  logic       weight_limit_exceeded = 1'b0;
  logic       door_motor_open;
  logic       door_motor_close;
  logic       door_is_closed;
  logic       move_permit;
  logic       door_fault;
  logic [1:0] door_state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  door_sequencer dut (
    .clk                   (clk),
    .button_reset          (button_reset),
    .door_tick             (door_tick),
    .arrived               (arrived),
    .open_btn              (open_btn),
    .close_btn             (close_btn),
    .weight_limit_exceeded (weight_limit_exceeded),
    .door_motor_open       (door_motor_open),
    .door_motor_close      (door_motor_close),
    .door_is_closed        (door_is_closed),
    .move_permit           (move_permit),
    .door_fault            (door_fault),
    .door_state            (door_state)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // one clock with the given tick level; returns #1 after the edge
  task automatic cyc(input logic tick);
    door_tick = tick;
    @(posedge clk);
    #1;
    door_tick = 1'b0;
  endtask

  // k door_tick periods: three quiet clocks then a tick clock
  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) begin
      cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
    end
  endtask

  task automatic pulse_arrived();
    arrived = 1'b1;
    cyc(1'b0);
    arrived = 1'b0;
  endtask

  // from CLOSING: open_btn raised on the cycle of the 2nd tick
  task automatic reopen_on_2nd_tick();
    ticks(1);
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    open_btn = 1'b1;
    cyc(1'b1);
    open_btn = 1'b0;
  endtask

  initial begin
    // 1: reset
    button_reset = 1'b1;
    cyc(1'b0); cyc(1'b0);
    button_reset = 1'b0;
    chk("rst_state", 8'(door_state), 8'd0);
    chk("rst_closed", 8'(door_is_closed), 8'd1);
    chk("rst_permit", 8'(move_permit), 8'd1);
    chk("rst_motors", 8'({door_motor_open, door_motor_close}), 8'd0);
    chk("rst_fault", 8'(door_fault), 8'd0);

    // overload in CLOSED drops permit combinationally
    weight_limit_exceeded = 1'b1;
    #1;
    chk("closed_overload_permit", 8'(move_permit), 8'd0);
    weight_limit_exceeded = 1'b0;
    #1;

    // 2: full cycle
    pulse_arrived();
    chk("arr_opening", 8'(door_state), 8'd1);
    chk("arr_motor_open", 8'(door_motor_open), 8'd1);
    chk("arr_permit", 8'(move_permit), 8'd0);
    ticks(1);
    chk("opening_tick1", 8'(door_state), 8'd1);
    ticks(1);
    chk("opening_tick2", 8'(door_state), 8'd2);
    chk("open_permit", 8'(move_permit), 8'd0);
    ticks(3);
    chk("open_tick3", 8'(door_state), 8'd2);
    ticks(1);
    chk("open_tick4", 8'(door_state), 8'd3);
    chk("closing_motor", 8'(door_motor_close), 8'd1);
    chk("closing_permit", 8'(move_permit), 8'd0);
    ticks(1);
    chk("closing_tick1", 8'(door_state), 8'd3);
    ticks(1);
    chk("closing_tick2", 8'(door_state), 8'd0);
    chk("closed_permit", 8'(move_permit), 8'd1);

    // ticks ignored in CLOSED
    ticks(3);
    chk("closed_ticks_idle", 8'(door_state), 8'd0);

    // 3: overload held in OPEN
    pulse_arrived();
    ticks(2);
    weight_limit_exceeded = 1'b1;
    #1;
    chk("ovl_permit", 8'(move_permit), 8'd0);
    ticks(20);
    chk("ovl_stays_open", 8'(door_state), 8'd2);
    weight_limit_exceeded = 1'b0;
    ticks(3);
    chk("ovl_rel_tick3", 8'(door_state), 8'd2);
    ticks(1);
    chk("ovl_rel_tick4", 8'(door_state), 8'd3);
    ticks(2);
    chk("ovl_closed", 8'(door_state), 8'd0);

    // 4: three reversals raise fault; full close clears it
    pulse_arrived();
    ticks(6);
    chk("rev_pre_closing", 8'(door_state), 8'd3);
    for (int r = 1; r <= 3; r++) begin
      reopen_on_2nd_tick();
      chk($sformatf("rev%0d_opening", r), 8'(door_state), 8'd1);
      chk($sformatf("rev%0d_fault", r), 8'(door_fault), (r == 3) ? 8'd1 : 8'd0);
      if (r < 3) ticks(6);
    end
    ticks(6);
    chk("fault_held_closing", 8'(door_fault), 8'd1);
    ticks(2);
    chk("fault_close_state", 8'(door_state), 8'd0);
    chk("fault_cleared", 8'(door_fault), 8'd0);
    chk("fault_cleared_permit", 8'(move_permit), 8'd1);

    // 5: open beats close; close alone closes in 1 clk
    pulse_arrived();
    ticks(2);
    close_btn = 1'b1;
    open_btn = 1'b1;
    cyc(1'b0);
    chk("both_btn_open", 8'(door_state), 8'd2);
    open_btn = 1'b0;
    cyc(1'b0);
    close_btn = 1'b0;
    chk("close_btn_closing", 8'(door_state), 8'd3);
    ticks(2);
    chk("close_btn_closed", 8'(door_state), 8'd0);

    // 6: reset aborts OPENING and clears fault/reopen count
    pulse_arrived();
    ticks(6);
    for (int r = 1; r <= 3; r++) begin
      reopen_on_2nd_tick();
      if (r < 3) ticks(6);
    end
    chk("pre_rst_fault", 8'(door_fault), 8'd1);
    button_reset = 1'b1;
    arrived = 1'b1;
    cyc(1'b0);
    button_reset = 1'b0;
    arrived = 1'b0;
    chk("midrst_state", 8'(door_state), 8'd0);
    chk("midrst_fault", 8'(door_fault), 8'd0);
    chk("midrst_motor", 8'(door_motor_open), 8'd0);
    // a single reversal after reset must not fault (reopen count cleared)
    pulse_arrived();
    ticks(6);
    reopen_on_2nd_tick();
    chk("post_rst_rev_state", 8'(door_state), 8'd1);
    chk("post_rst_rev_fault", 8'(door_fault), 8'd0);
    ticks(8);
    chk("post_rst_closed", 8'(door_state), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
